aquarium_light_sequencer: RTL
=============================

// Module: aquarium_light_sequencer
// PURPOSE
//  Parametrised day/evening/night lighting sequencer for the aquarium hub.
//  - Keeps minute-of-day; resolves mode from programmable boundaries.
//  - Fades N LED channels linearly to each mode's colour; drives one PWM output per channel.
//  - Raises feed requests at programmable times.
// PARAMETERS
//  CH_N      3    LED channel count (R,G,B by default)
//  CW        8    channel level width; PWM period 2**CW clocks
//  FADE_DIV  1024 clocks per 1-LSB fade step (>=1)
//  AMB_THR   128  ambient threshold (used only with AMBIENT_DIM_EN)
// PORTS
//  clock          in   1        system clock
//  reset_n        in   1        synchronous, active-low reset
//  minute_tick    in   1        one-cycle pulse: advance minute-of-day
//  time_load      in   1        load time_val into minute counter
//  time_val       in   11       minute 0..1439
//  cfg_day_start  in   11       day begins (minute)
//  cfg_eve_start  in   11       evening begins
//  cfg_ngt_start  in   11       night begins
//  cfg_day_col    in   CH_N*CW  day target levels, ch0 in LSBs
//  cfg_eve_col    in   CH_N*CW  evening target levels
//  cfg_ngt_col    in   CH_N*CW  night target levels
//  cfg_feed0/1    in   11       feed times; value >=1440 disables that slot
//  feed_ack       in   1        feeder accepted request
//  minute         out  11       current minute-of-day
//  mode           out  2        00 day, 01 evening, 10 night
//  fading         out  1        fade in progress
//  level          out  CH_N*CW  current channel levels
//  pwm_out        out  CH_N     PWM per channel
//  feed_req       out  1        held until feed_ack
//  feed_overrun   out  1        one-cycle pulse: feed event while feed_req pending
//  amb_lvl        in   CW       ambient light (only with AMBIENT_DIM_EN)
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): minute=0, mode=10, fading=0, level=0, pwm_out=0,
//    feed_req=0, feed_overrun=0, fade/PWM counters=0.
//  Minute counter: time_load wins over minute_tick. Load of time_val>=1440 is ignored.
//    Tick at 1439 wraps to 0. Both update in the cycle after the strobe.
//  Target mode (combinational from minute, cyclic windows):
//    day = [day_start, eve_start), eve = [eve_start, ngt_start), night = [ngt_start, day_start).
//    All windows wrap through 0. If two boundaries are equal, the later-named mode in the
//    order day<eve<night wins. If all three are equal: night.
//  FSM states:
//    STEADY: if target!=mode or level!=target colour -> FADE, fading=1 next cycle.
//    FADE: every FADE_DIV clocks, each channel level moves 1 LSB toward target, saturating at
//      target. When all channels equal target: mode<=target, fading<=0 -> STEADY.
//      Target change mid-fade: retarget from current levels; no jump; fade divider not reset.
//      Colour-config change in STEADY: re-fade; mode stays.
//  Fade time = max|delta| * FADE_DIV clocks. Example: 0->255 with FADE_DIV=4 takes 1020 clocks.
//  PWM: free-running CW-bit counter. pwm_out[i] = (cnt < eff_level[i]), registered (1-clock latency).
//    Level 0 = always low; 2**CW-1 = high 2**CW-1 of 2**CW clocks. eff_level latched at cnt wrap
//    (glitch-free).
//  Feed: event when minute becomes equal to an enabled cfg_feedK (via tick or load).
//    Event sets feed_req next cycle. feed_ack while feed_req=1 clears it next cycle;
//    ack with feed_req=0 is ignored. Event while feed_req=1: feed_req stays 1,
//    feed_overrun pulses. Both slots equal: single event.
//  Reset mid-fade/mid-request: all state returns to reset values; no request is retained.
// CONFIGURATION
//  AMBIENT_DIM_EN defined:
//    - amb_lvl port present; sampled at PWM wrap.
//    - amb_lvl > AMB_THR -> eff_level = level>>1 (half brightness); otherwise eff_level = level.
//    - level output is unaffected.
//  AMBIENT_DIM_EN undefined: no amb_lvl port; eff_level = level.
// TESTING
//  1 Reset, defaults day=480 eve=1020 ngt=1260, ngt_col=0x000080, FADE_DIV=4
//    -> mode=10, blue level reaches 0x80 after 512 clocks, fading falls.
//  2 Load 1019, one tick -> minute=1020, fading=1, then mode=01 with level=eve_col.
//    Tick at 1439 -> minute=0.
//  3 Day->evening fade; at half-way load 300 (night)
//    -> levels reverse from current value with no step >1 LSB; end mode=10.
//  4 cfg_feed0=480: tick into 480 -> feed_req=1; hold ack low, reload 480 -> feed_overrun one pulse;
//    ack -> feed_req=0 next cycle.
//  5 level=64, CW=8 -> pwm_out high exactly 64 of 256 clocks. Level 0 -> never high.
//  6 AMBIENT_DIM_EN, level=200, amb_lvl=200 -> 100/256 duty from next PWM wrap;
//    amb_lvl=10 -> 200/256.

Source files
------------

// File: rtl/aquarium_light_sequencer.sv
// Aquarium lighting sequencer: minute-of-day clock, day/evening/night resolver, linear LED fader, per-channel PWM, feed scheduler.
// Latency: minute/feed_req/feed_overrun update 1 clock after the strobe; one fade step every FADE_DIV clocks; pwm_out 1 clock after the PWM counter.
// Backpressure: feed_req is held until feed_ack; a feed event while a request is pending pulses feed_overrun instead of queueing.
//
// Ports:
//   clock, reset_n            system clock, synchronous active-low reset
//   minute_tick, time_load    advance / load the minute-of-day (load wins; loads >= 1440 ignored)
//   time_val                  minute to load, 0..1439
//   cfg_{day,eve,ngt}_start   mode boundaries in minutes (cyclic windows)
//   cfg_{day,eve,ngt}_col     per-mode target levels, channel 0 in the LSBs
//   cfg_feed0/1, feed_ack     feed times (>= 1440 disables a slot) and feeder handshake
//   amb_lvl                   ambient light level (AMBIENT_DIM_EN builds only)
//   minute, mode, fading      current minute, settled mode (00 day, 01 eve, 10 night), fade active
//   level, pwm_out            current channel levels and their PWM outputs
//   feed_req, feed_overrun    pending feed request, one-cycle overrun pulse
//
// Build option: define AMBIENT_DIM_EN to add amb_lvl; when amb_lvl > AMB_THR at a PWM
// wrap the next PWM period runs at half the level (the level output is unaffected).

module aquarium_light_sequencer #(
    parameter int CH_N     = 3,
    parameter int CW       = 8,
    parameter int FADE_DIV = 1024,
    parameter int AMB_THR  = 128
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 minute_tick,
    input  logic                 time_load,
    input  logic [10:0]          time_val,
    input  logic [10:0]          cfg_day_start,
    input  logic [10:0]          cfg_eve_start,
    input  logic [10:0]          cfg_ngt_start,
    input  logic [CH_N*CW-1:0]   cfg_day_col,
    input  logic [CH_N*CW-1:0]   cfg_eve_col,
    input  logic [CH_N*CW-1:0]   cfg_ngt_col,
    input  logic [10:0]          cfg_feed0,
    input  logic [10:0]          cfg_feed1,
    input  logic                 feed_ack,
`ifdef AMBIENT_DIM_EN
    input  logic [CW-1:0]        amb_lvl,
`endif
    output logic [10:0]          minute,
    output logic [1:0]           mode,
    output logic                 fading,
    output logic [CH_N*CW-1:0]   level,
    output logic [CH_N-1:0]      pwm_out,
    output logic                 feed_req,
    output logic                 feed_overrun
);

    localparam logic [10:0] MIN_N = 11'd1440;
    localparam int DW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(FADE_DIV - 1);

    typedef enum logic [1:0] {
        MODE_DAY = 2'b00,
        MODE_EVE = 2'b01,
        MODE_NGT = 2'b10
    } mode_e;

    typedef enum logic {
        ST_STEADY = 1'b0,
        ST_FADE   = 1'b1
    } state_e;

    typedef logic [CH_N-1:0][CW-1:0] lvl_t;

    // Minutes elapsed since boundary b, going backwards around the 1440-minute day.
    function automatic logic [11:0] since(input logic [10:0] m, input logic [10:0] b);
        if (m >= b) since = {1'b0, m} - {1'b0, b};
        else        since = {1'b0, m} + 12'd1440 - {1'b0, b};
    endfunction

    logic [10:0]   minute_q, minute_d;
    logic          feed_req_q, feed_req_d;
    logic          feed_ovr_q, feed_ovr_d;
    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic          fading_q, fading_d;
    lvl_t          level_q, level_d;
    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    lvl_t          eff_q, eff_d;
    logic [CH_N-1:0] pwm_q, pwm_d;

    logic          min_upd;
    logic          feed_hit;
    logic [11:0]   age_day, age_eve, age_ngt;
    mode_e         tgt_mode;
    lvl_t          tgt_col;
    lvl_t          day_col, eve_col, ngt_col;
    lvl_t          lvl_step;
    lvl_t          eff_new;
    logic          fade_tick;

    assign day_col = cfg_day_col;
    assign eve_col = cfg_eve_col;
    assign ngt_col = cfg_ngt_col;

    // Minute counter and feed scheduling. A feed event fires on any accepted
    // tick or load whose resulting minute matches an enabled slot, including a
    // reload of the current minute; equal slots collapse into one event.
    always_comb begin
        minute_d = minute_q;
        min_upd  = 1'b0;
        if (time_load) begin
            if (time_val < MIN_N) begin
                minute_d = time_val;
                min_upd  = 1'b1;
            end
        end else if (minute_tick) begin
            minute_d = (minute_q == MIN_N - 11'd1) ? 11'd0 : minute_q + 11'd1;
            min_upd  = 1'b1;
        end

        feed_hit = min_upd &&
                   (((cfg_feed0 < MIN_N) && (minute_d == cfg_feed0)) ||
                    ((cfg_feed1 < MIN_N) && (minute_d == cfg_feed1)));
        feed_req_d = feed_hit | (feed_req_q & ~feed_ack);
        feed_ovr_d = feed_hit & feed_req_q & ~feed_ack;
    end

    // Target mode is the boundary passed most recently; on a tie (equal
    // boundaries) night beats evening beats day.
    always_comb begin
        age_day  = since(minute_q, cfg_day_start);
        age_eve  = since(minute_q, cfg_eve_start);
        age_ngt  = since(minute_q, cfg_ngt_start);
        tgt_mode = MODE_NGT;
        tgt_col  = ngt_col;
        if (!((age_ngt <= age_eve) && (age_ngt <= age_day))) begin
            if (age_eve <= age_day) begin
                tgt_mode = MODE_EVE;
                tgt_col  = eve_col;
            end else begin
                tgt_mode = MODE_DAY;
                tgt_col  = day_col;
            end
        end
    end

    // One-LSB move toward the target, saturating at the target.
    always_comb begin
        lvl_step = level_q;
        for (int i = 0; i < CH_N; i++) begin
            if (level_q[i] < tgt_col[i])      lvl_step[i] = level_q[i] + 1'b1;
            else if (level_q[i] > tgt_col[i]) lvl_step[i] = level_q[i] - 1'b1;
        end
    end

    assign fade_tick = (div_q == DIV_LAST);

    // Fade FSM. The divider is parked at zero while steady so a fresh fade
    // takes exactly max|delta| * FADE_DIV clocks; a retarget mid-fade keeps it
    // running and simply steps from the current levels toward the new colour.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        fading_d = fading_q;
        level_d  = level_q;
        div_d    = div_q;
        case (state_q)
            ST_STEADY: begin
                div_d = '0;
                if ((tgt_mode != mode_q) || (level_q != tgt_col)) begin
                    state_d  = ST_FADE;
                    fading_d = 1'b1;
                end
            end
            ST_FADE: begin
                if (fade_tick) begin
                    level_d = lvl_step;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
                if (level_d == tgt_col) begin
                    state_d  = ST_STEADY;
                    mode_d   = tgt_mode;
                    fading_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_STEADY;
            end
        endcase
    end

    // PWM: effective levels only change at counter wrap so a period is never cut short.
    always_comb begin
        eff_new = level_q;
`ifdef AMBIENT_DIM_EN
        if (amb_lvl > CW'(AMB_THR)) begin
            for (int i = 0; i < CH_N; i++) eff_new[i] = level_q[i] >> 1;
        end
`endif
        cnt_d = cnt_q + 1'b1;
        eff_d = (&cnt_q) ? eff_new : eff_q;
        for (int i = 0; i < CH_N; i++) pwm_d[i] = (cnt_q < eff_q[i]);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            minute_q   <= '0;
            feed_req_q <= 1'b0;
            feed_ovr_q <= 1'b0;
            state_q    <= ST_STEADY;
            mode_q     <= MODE_NGT;
            fading_q   <= 1'b0;
            level_q    <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            eff_q      <= '0;
            pwm_q      <= '0;
        end else begin
            minute_q   <= minute_d;
            feed_req_q <= feed_req_d;
            feed_ovr_q <= feed_ovr_d;
            state_q    <= state_d;
            mode_q     <= mode_d;
            fading_q   <= fading_d;
            level_q    <= level_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            eff_q      <= eff_d;
            pwm_q      <= pwm_d;
        end
    end

    assign minute       = minute_q;
    assign mode         = mode_q;
    assign fading       = fading_q;
    assign level        = level_q;
    assign pwm_out      = pwm_q;
    assign feed_req     = feed_req_q;
    assign feed_overrun = feed_ovr_q;

endmodule
